ofifo_row_aligner: RTL and testbench

- Output FIFO between the MAC array and the SFU.
- Each of the `col` array columns pushes psums independently, with column-skewed timing. The block re-aligns them into complete rows.
- It presents a row on `ofifo_valid` / `ofifo_data` only when every column holds at least one entry. The SFU consumes the row with a one-cycle `rd` pulse.
- One instance per core, sitting directly upstream of the SFU.

---
 rtl/ofifo_row_aligner_pkg.sv | 14 +
 rtl/ofifo_lane.sv | 53 +++++
 rtl/ofifo_row_aligner.sv | 55 +++++
 tb/tb_ofifo_row_aligner.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_row_aligner_pkg.sv
// rtl/ofifo_row_aligner_pkg.sv - shared constants for the output FIFO row aligner
package ofifo_row_aligner_pkg;

    localparam int PSUM_BW     = 16;
    localparam int COL         = 8;
    localparam int OFIFO_DEPTH = 64;
    localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

    // Extra MSB lets equal low bits mean either empty or full.
    function automatic int ptr_width(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// rtl/ofifo_lane.sv - single-column first-word fall-through FIFO lane
module ofifo_lane
    import ofifo_row_aligner_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [psum_bw-1:0] din,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    localparam int ptr_w  = ptr_width(depth);
    localparam int addr_w = ptr_w - 1;

    logic [psum_bw-1:0] mem [depth];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic               do_pop;
    logic               do_push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[addr_w] != rptr[addr_w]) &&
                   (wptr[addr_w-1:0] == rptr[addr_w-1:0]);

    // A pop on the same edge frees the slot, so a full lane may still accept.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;

    assign dout = mem[rptr[addr_w-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + ptr_w'(1);
            if (do_pop)  rptr <= rptr + ptr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[addr_w-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo_row_aligner.sv
// rtl/ofifo_row_aligner.sv - re-aligns column-skewed psums into complete rows for the SFU
module ofifo_row_aligner
    import ofifo_row_aligner_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd,
    output logic                   ofifo_valid,
    output logic [psum_bw*col-1:0] ofifo_data,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col-1:0]         drop;
    logic [psum_bw*col-1:0] head;
    logic                   pop;

    assign ofifo_valid = ~|empty;
    assign pop         = rd & ofifo_valid;
    assign o_full      = |full;
    assign o_ready     = ~o_full;
    assign ofifo_data  = ofifo_valid ? head : '0;

    for (genvar c = 0; c < col; c++) begin : g_lane
        ofifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .push  (wr[c]),
            .pop   (pop),
            .din   (in[c*psum_bw +: psum_bw]),
            .dout  (head[c*psum_bw +: psum_bw]),
            .empty (empty[c]),
            .full  (full[c]),
            .drop  (drop[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     o_overflow <= 1'b0;
        else if (|drop) o_overflow <= 1'b1;
    end

endmodule

// File: tb/tb_ofifo_row_aligner.sv
// tb/tb_ofifo_row_aligner.sv - directed self-checking bench for ofifo_row_aligner
module tb_ofifo_row_aligner;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   wr;
    logic [127:0] din;
    logic         rd;
    logic         ofifo_valid;
    logic [127:0] ofifo_data;
    logic         o_full;
    logic         o_ready;
    logic         o_overflow;

    int total = 0;
    int bad   = 0;

    ofifo_row_aligner dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .in          (din),
        .rd          (rd),
        .ofifo_valid (ofifo_valid),
        .ofifo_data  (ofifo_data),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_all(input logic [15:0] v);
        for (int c = 0; c < 8; c++) din[c*16 +: 16] = v;
    endtask

    logic [127:0] row_exp;

    initial begin
        reset = 1'b0;
        wr    = '0;
        din   = '0;
        rd    = 1'b0;
        #2;
        check("rst_valid", ofifo_valid, 0);
        check("rst_full", o_full, 0);
        check("rst_ready", o_ready, 1);
        check("rst_ovf", o_overflow, 0);
        check("rst_data", ofifo_data, 0);
        step();
        reset = 1'b1;
        step();

        // skewed fill, one lane per cycle
        for (int c = 0; c < 8; c++) begin
            wr = 8'(1 << c);
            din = '0;
            din[c*16 +: 16] = 16'h0100 + 16'(c);
            step();
            check("skew_valid", ofifo_valid, (c == 7) ? 1 : 0);
        end
        wr = '0;
        row_exp = {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                   16'h0103, 16'h0102, 16'h0101, 16'h0100};
        check("skew_data", ofifo_data, row_exp);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("skew_pop_valid", ofifo_valid, 0);

        // lane 3 full and overflow
        din = '0;
        for (int k = 1; k <= 65; k++) begin
            wr = 8'h08;
            din[48 +: 16] = 16'(k);
            step();
            if (k == 63) check("full_63", o_full, 0);
            if (k == 64) begin
                check("full_64", o_full, 1);
                check("ready_64", o_ready, 0);
                check("ovf_64", o_overflow, 0);
            end
            if (k == 65) check("ovf_65", o_overflow, 1);
        end
        wr = 8'hF7;
        for (int k = 1; k <= 64; k++) begin
            fill_all(16'(k));
            step();
        end
        wr = '0;
        for (int k = 1; k <= 64; k++) begin
            check("lane3_order", ofifo_data[48 +: 16], 16'(k));
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        check("lane3_drained", ofifo_valid, 0);
        check("ovf_sticky", o_overflow, 1);

        // async reset mid-cycle with a row held
        wr = 8'hFF;
        fill_all(16'h5555);
        step();
        wr = '0;
        check("pre_rst_valid", ofifo_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", ofifo_valid, 0);
        check("arst_full", o_full, 0);
        check("arst_ready", o_ready, 1);
        check("arst_ovf", o_overflow, 0);
        check("arst_data", ofifo_data, 0);
        step();
        reset = 1'b1;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("arst_rd_valid", ofifo_valid, 0);

        // pop plus write on a full lane
        wr = 8'hFF;
        for (int k = 1; k <= 64; k++) begin
            fill_all(16'(k));
            step();
        end
        check("pw_full", o_full, 1);
        rd = 1'b1;
        wr = 8'h01;
        din[0 +: 16] = 16'hBEEF;
        step();
        rd = 1'b0;
        check("pw_ovf", o_overflow, 0);
        check("pw_full_after", o_full, 1);
        wr = 8'hFE;
        fill_all(16'd65);
        step();
        wr = '0;
        for (int k = 2; k <= 65; k++) begin
            check("pw_lane0", ofifo_data[0 +: 16], (k == 65) ? 16'hBEEF : 16'(k));
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        check("pw_drained", ofifo_valid, 0);
        check("pw_full_end", o_full, 0);
        check("pw_ovf_end", o_overflow, 0);

        // streaming bursts with rd held high
        for (int b = 0; b < 3; b++) begin
            rd = 1'b1;
            for (int r = 0; r <= 36; r++) begin
                if (r < 36) begin
                    wr = 8'hFF;
                    for (int c = 0; c < 8; c++)
                        din[c*16 +: 16] = 16'(b*4096 + r*16 + c);
                end else begin
                    wr = '0;
                end
                row_exp = din;
                step();
                if (r < 36) begin
                    check("strm_valid", ofifo_valid, 1);
                    check("strm_data", ofifo_data, row_exp);
                end else begin
                    check("strm_end_valid", ofifo_valid, 0);
                end
            end
            rd = 1'b0;
        end
        check("strm_ovf", o_overflow, 0);

        // spurious rd while lane 7 is empty
        wr = 8'h7F;
        for (int c = 0; c < 8; c++) din[c*16 +: 16] = 16'h00A0 + 16'(c);
        step();
        wr = '0;
        rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("spur_valid", ofifo_valid, 0);
        end
        rd = 1'b0;
        wr = 8'h80;
        step();
        wr = '0;
        check("spur_late_valid", ofifo_valid, 1);
        row_exp = {16'h00A7, 16'h00A6, 16'h00A5, 16'h00A4,
                   16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        check("spur_heads", ofifo_data, row_exp);
        check("spur_ovf", o_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
